// File: rtl/trace_buffer.sv
// Commit-event trace buffer: captures GRF (W stage) and DM (M stage) writes in
// program order into a FWFT FIFO with sequence tags, freeze request and drop accounting.
module trace_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          grf_we,
    input  logic [31:0]   grf_pc,
    input  logic [4:0]    grf_addr,
    input  logic [31:0]   grf_wd,
    input  logic          dm_we,
    input  logic [31:0]   dm_pc,
    input  logic [31:0]   dm_addr,
    input  logic [31:0]   dm_wd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_kind,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_addr,
    output logic [31:0]   out_data,
    output logic [15:0]   out_seq,
    output logic [AW:0]   count,
    output logic          hold,
    output logic          overflow,
    output logic [15:0]   drop_cnt
);

    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] LP_HOLD  = (AW+1)'(DEPTH - 2);

    logic [AW:0]   r_count;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [15:0]   r_seq;
    logic [15:0]   r_drop;
    logic          r_ovf;

    logic          r_kind [DEPTH];
    logic [31:0]   r_pc   [DEPTH];
    logic [31:0]   r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [15:0]   r_tag  [DEPTH];

    logic          w_g;
    logic          w_d;
    logic [AW:0]   w_free;
    logic          w_acc_g;
    logic          w_acc_d;
    logic [1:0]    w_ndrop;
    logic          w_pop;
    logic [AW-1:0] w_wptr_d;
    logic [15:0]   w_seq_d;
    logic [16:0]   w_drop_sum;

    // Free space is taken before any same-cycle pop; DM only gets a slot left over by GRF.
    always_comb begin
        w_g        = grf_we && (grf_addr != '0);
        w_d        = dm_we;
        w_free     = LP_DEPTH - r_count;
        w_acc_g    = w_g && (w_free != '0);
        w_acc_d    = w_d && (w_free > {{AW{1'b0}}, w_acc_g});
        w_ndrop    = 2'(w_g && !w_acc_g) + 2'(w_d && !w_acc_d);
        w_pop      = (r_count != '0) && out_ready;
        w_wptr_d   = r_wptr + AW'(w_acc_g);
        w_seq_d    = r_seq + 16'(w_g);
        w_drop_sum = {1'b0, r_drop} + 17'(w_ndrop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_seq   <= '0;
            r_drop  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= r_count + (AW+1)'(w_acc_g) + (AW+1)'(w_acc_d) - (AW+1)'(w_pop);
            r_wptr  <= r_wptr + AW'(w_acc_g) + AW'(w_acc_d);
            r_rptr  <= r_rptr + AW'(w_pop);
            r_seq   <= r_seq + 16'(w_g) + 16'(w_d);
            if (w_ndrop != '0)
                r_ovf <= 1'b1;
            r_drop  <= w_drop_sum[16] ? '1 : w_drop_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc_g) begin
            r_kind[r_wptr] <= 1'b0;
            r_pc[r_wptr]   <= grf_pc;
            r_addr[r_wptr] <= {27'b0, grf_addr};
            r_data[r_wptr] <= grf_wd;
            r_tag[r_wptr]  <= r_seq;
        end
        if (w_acc_d) begin
            r_kind[w_wptr_d] <= 1'b1;
            r_pc[w_wptr_d]   <= dm_pc;
            r_addr[w_wptr_d] <= dm_addr;
            r_data[w_wptr_d] <= dm_wd;
            r_tag[w_wptr_d]  <= w_seq_d;
        end
    end

    assign out_valid = (r_count != '0);
    assign out_kind  = r_kind[r_rptr];
    assign out_pc    = r_pc[r_rptr];
    assign out_addr  = r_addr[r_rptr];
    assign out_data  = r_data[r_rptr];
    assign out_seq   = r_tag[r_rptr];
    assign count     = r_count;
    assign hold      = (r_count >= LP_HOLD);
    assign overflow  = r_ovf;
    assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_trace_buffer.sv
// Scoreboard bench for trace_buffer: expected entries are queued when events are
// driven and compared against the head when the drain accepts it.
module tb_trace_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          grf_we, dm_we, out_ready;
    logic [31:0]   grf_pc, grf_wd, dm_pc, dm_addr, dm_wd;
    logic [4:0]    grf_addr;
    logic          out_valid, out_kind, hold, overflow;
    logic [31:0]   out_pc, out_addr, out_data;
    logic [15:0]   out_seq, drop_cnt;
    logic [AW:0]   count;

    trace_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_wd(grf_wd),
        .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_wd(dm_wd),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data), .out_seq(out_seq),
        .count(count), .hold(hold), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] seq;
    } ev_t;

    ev_t         sbq[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] m_seq;
    logic        m_ovf;
    int          m_drop;
    logic [15:0] last_seq;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_drop();
        m_ovf = 1'b1;
        if (m_drop < 16'hFFFF)
            m_drop++;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic gwe, input logic [4:0] ga, input logic [31:0] gpc,
                        input logic [31:0] gwd, input logic dwe, input logic [31:0] dpc,
                        input logic [31:0] da, input logic [31:0] dwd, input logic rdy);
        ev_t e;
        int  free;
        grf_we = gwe; grf_addr = ga; grf_pc = gpc; grf_wd = gwd;
        dm_we = dwe; dm_pc = dpc; dm_addr = da; dm_wd = dwd;
        out_ready = rdy;
        #1;
        check_val("count", count, sbq.size());
        check_val("out_valid", out_valid, sbq.size() != 0);
        check_val("hold", hold, sbq.size() >= DEPTH - 2);
        check_val("overflow", overflow, m_ovf);
        check_val("drop_cnt", drop_cnt, m_drop);
        free = DEPTH - sbq.size();
        if (rdy && sbq.size() != 0) begin
            e = sbq.pop_front();
            check_val("out_kind", out_kind, e.kind);
            check_val("out_pc", out_pc, e.pc);
            check_val("out_addr", out_addr, e.addr);
            check_val("out_data", out_data, e.data);
            check_val("out_seq", out_seq, e.seq);
            last_seq = out_seq;
        end
        if (gwe && ga != 5'd0) begin
            e = '{1'b0, gpc, {27'b0, ga}, gwd, m_seq};
            m_seq++;
            if (free > 0) begin sbq.push_back(e); free--; end
            else model_drop();
        end
        if (dwe) begin
            e = '{1'b1, dpc, da, dwd, m_seq};
            m_seq++;
            if (free > 0) begin sbq.push_back(e); free--; end
            else model_drop();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 5'd0, '0, '0, 1'b0, '0, '0, '0, rdy);
    endtask

    task automatic gpush(input logic [4:0] ga, input logic [31:0] gpc, input logic [31:0] gwd,
                         input logic rdy);
        step(1'b1, ga, gpc, gwd, 1'b0, '0, '0, '0, rdy);
    endtask

    task automatic drain_all();
        int bound = 64;
        while (sbq.size() != 0 && bound > 0) begin
            idle(1'b1);
            bound--;
        end
        check_val("drain_done", count, 0);
    endtask

    task automatic do_reset();
        grf_we = 1'b0; dm_we = 1'b0; out_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_val("rst_count", count, 0);
        check_val("rst_valid", out_valid, 0);
        check_val("rst_hold", hold, 0);
        check_val("rst_ovf", overflow, 0);
        check_val("rst_drop", drop_cnt, 0);
        sbq.delete();
        m_seq = '0; m_ovf = 1'b0; m_drop = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        grf_we = 1'b0; grf_addr = '0; grf_pc = '0; grf_wd = '0;
        dm_we = 1'b0; dm_pc = '0; dm_addr = '0; dm_wd = '0; out_ready = 1'b0;
        m_seq = '0; m_ovf = 1'b0; m_drop = 0; last_seq = '0;
        @(negedge clk);
        do_reset();

        // Single GRF event, then drain it
        gpush(5'd5, 32'h3000, 32'h1234, 1'b0);
        check_val("t2_valid", out_valid, 1);
        check_val("t2_kind", out_kind, 0);
        idle(1'b1);
        check_val("t2_seq", last_seq, 0);
        check_val("t2_count", count, 0);
        check_val("t2_empty", out_valid, 0);

        // $0 writes take neither a slot nor a sequence number
        do_reset();
        gpush(5'd0, 32'h3000, 32'h5555, 1'b0);
        check_val("t3_count", count, 0);
        gpush(5'd3, 32'h3004, 32'h6666, 1'b0);
        idle(1'b1);
        check_val("t3_seq", last_seq, 0);

        // Dual push: GRF older than DM
        do_reset();
        step(1'b1, 5'd8, 32'h3004, 32'd7, 1'b1, 32'h3008, 32'h10, 32'hFF, 1'b0);
        check_val("t4_count", count, 2);
        idle(1'b1);
        check_val("t4_seq0", last_seq, 0);
        idle(1'b1);
        check_val("t4_seq1", last_seq, 1);

        // Fill, hold, overflow at full
        do_reset();
        for (int unsigned i = 0; i < 14; i++)
            gpush(5'(i % 31 + 1), 32'h4000 + i * 4, i, 1'b0);
        check_val("t5_hold", hold, 1);
        gpush(5'd9, 32'h4100, 32'hA, 1'b0);
        gpush(5'd10, 32'h4104, 32'hB, 1'b0);
        check_val("t5_full", count, 16);
        step(1'b1, 5'd11, 32'h4108, 32'hC, 1'b1, 32'h410C, 32'h20, 32'hD, 1'b0);
        check_val("t5_ovf", overflow, 1);
        check_val("t5_drop", drop_cnt, 2);
        check_val("t5_count", count, 16);
        drain_all();
        check_val("t5_last", last_seq, 15);
        gpush(5'd12, 32'h4110, 32'hE, 1'b0);
        idle(1'b1);
        check_val("t5_next", last_seq, 18);

        // Full with same-cycle pop: pop does not free a slot for the push
        do_reset();
        for (int unsigned i = 0; i < 16; i++)
            gpush(5'd7, 32'h5000 + i * 4, i, 1'b0);
        gpush(5'd13, 32'h5100, 32'h77, 1'b1);
        check_val("t6_count", count, 15);
        check_val("t6_drop", drop_cnt, 1);
        step(1'b1, 5'd14, 32'h5104, 32'h88, 1'b1, 32'h5108, 32'h30, 32'h99, 1'b0);
        check_val("t6_count2", count, 16);
        check_val("t6_drop2", drop_cnt, 2);
        drain_all();

        // Asynchronous reset with entries queued
        do_reset();
        for (int unsigned i = 0; i < 5; i++)
            gpush(5'd4, 32'h6000 + i * 4, i, 1'b0);
        check_val("t1_pre", count, 5);
        do_reset();
        gpush(5'd6, 32'h6100, 32'h42, 1'b0);
        idle(1'b1);
        check_val("t1_seq", last_seq, 0);

        // Random traffic, including $0 writes and backpressure
        for (int unsigned i = 0; i < 400; i++)
            step(1'($urandom), 5'($urandom_range(0, 3)), $urandom, $urandom,
                 1'($urandom), $urandom, $urandom, $urandom, ($urandom_range(0, 2) != 0));
        drain_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
